pos_dac_spi_tx: RTL and testbench

//  Serial DAC writer for the galvo position loop. Takes each 16-bit offset-binary code
//  the position PID produces (32768 = mid-scale), frames it as a 24-bit SPI word and

---
 rtl/galvano_dac_pkg.sv | 25 ++
 rtl/dac_sclk_gen.sv | 48 ++++
 rtl/pos_dac_spi_tx.sv | 200 ++++++++++++++++++++
 tb/tb_pos_dac_spi_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/galvano_dac_pkg.sv
// Purpose: shared types and constants for the galvo position DAC writer.
// Latency: n/a (types, constants and a framing helper only).
// Backpressure: n/a.
package galvano_dac_pkg;

    localparam int          FRAME_BITS   = 24;
    localparam logic [15:0] DAC_MIDSCALE = 16'd32768;

    // Frame sequencer states; ST_LDAC is only reachable when the LDAC pulse is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_LDAC,
        ST_GAP
    } dac_state_t;

    // The code is passed through untouched; only the command byte is prepended.
    function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [7:0]  cmd,
                                                        input logic [15:0] code);
        return {cmd, code};
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Purpose: SCLK half-period divider; emits a half-period tick and SCLK rise/fall enables.
// Latency: tick every CLK_DIV cycles while run is high; counter held at 0 otherwise.
// Backpressure: none; sclk only toggles while shift_en is high and is parked low otherwise.
module dac_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic sys_rst,
    input  logic run,
    input  logic shift_en,
    output logic tick,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic sclk
);

    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick      = run && (div_cnt == CNT_MAX);
    assign sclk_rise = shift_en && tick && !sclk;
    assign sclk_fall = shift_en && tick && sclk;

    // Half-period counter: runs 0..CLK_DIV-1, parked at 0 whenever the sequencer is not timing a state.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // SCLK register: toggles on each half-period tick during SHIFT, idles low (mode 0).
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            sclk <= 1'b0;
        end else if (!shift_en) begin
            sclk <= 1'b0;
        end else if (tick) begin
            sclk <= !sclk;
        end
    end

endmodule

// File: rtl/pos_dac_spi_tx.sv
// Purpose: frames 16-bit offset-binary PID codes as {CMD_BYTE, code}, shifts them MSB-first to the galvo DAC.
// Latency: dac_csn falls 1 cycle after dac_code_valid; dac_done 206 cycles later (202 without DAC_LDAC_EN).
// Backpressure: none; one-deep pending slot, newest code wins, overwrites counted in dac_overrun.
// Build option DAC_LDAC_EN: adds an LDAC low pulse after csn rises; when undefined dac_ldacn is tied high.
module pos_dac_spi_tx
    import galvano_dac_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [7:0] CMD_BYTE = 8'h00,
    parameter int         CS_GAP   = 2
) (
    input  logic        clk_sys,
    input  logic        sys_rst,
    input  logic        dac_code_valid,
    input  logic [15:0] dac_code,
    output logic        dac_busy,
    output logic        dac_done,
    output logic [15:0] dac_overrun,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_csn,
    output logic        dac_ldacn
);

    localparam int            GW      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(CS_GAP - 1);
    localparam logic [4:0]    TOP_BIT = 5'(FRAME_BITS - 1);

    dac_state_t            state_q;
    dac_state_t            state_nxt;
    logic                  load_new;
    logic                  load_pend;
    logic [FRAME_BITS-1:0] shift_q;
    logic [4:0]            bit_cnt;
    logic                  last_smp_q;
    logic                  pend_vld;
    logic [15:0]           pend_code;
    logic [15:0]           overrun_q;
    logic [GW-1:0]         gap_cnt;
    logic                  gap_last;
    logic                  csn_q;
    logic                  div_run;
    logic                  div_tick;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  sclk_q;

    assign div_run  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_HOLD)  || (state_q == ST_LDAC);
    assign gap_last = (gap_cnt == GAP_MAX);

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_sys   (clk_sys),
        .sys_rst   (sys_rst),
        .run       (div_run),
        .shift_en  (state_q == ST_SHIFT),
        .tick      (div_tick),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .sclk      (sclk_q)
    );

    // Next-state and load decisions; a pending code always takes precedence over a fresh one.
    always_comb begin
        state_nxt = state_q;
        load_new  = 1'b0;
        load_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_vld) begin
                    load_pend = 1'b1;
                    state_nxt = ST_SETUP;
                end else if (dac_code_valid) begin
                    load_new  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: if (div_tick) state_nxt = ST_SHIFT;
            ST_SHIFT: if (sclk_fall && last_smp_q) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (div_tick) begin
`ifdef DAC_LDAC_EN
                    state_nxt = ST_LDAC;
`else
                    state_nxt = ST_GAP;
`endif
                end
            end
            ST_LDAC: if (div_tick) state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_last) begin
                    if (pend_vld) begin
                        load_pend = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops straight to IDLE so a partial frame is abandoned.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Shift register and bit tracking: mosi advances on each SCLK fall, bit 0 sampled marks the end.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            last_smp_q <= 1'b0;
        end else if (load_new || load_pend) begin
            shift_q    <= dac_frame(CMD_BYTE, load_new ? dac_code : pend_code);
            bit_cnt    <= TOP_BIT;
            last_smp_q <= 1'b0;
        end else begin
            if (sclk_fall) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                if (bit_cnt != 5'd0) begin
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end
            if (sclk_rise && (bit_cnt == 5'd0)) begin
                last_smp_q <= 1'b1;
            end
        end
    end

    // Pending slot and overrun count; a code landing in the same cycle the slot drains is not an overrun.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            pend_vld  <= 1'b0;
            pend_code <= '0;
            overrun_q <= '0;
        end else if (dac_code_valid && !load_new) begin
            pend_vld  <= 1'b1;
            pend_code <= dac_code;
            if (pend_vld && !load_pend && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'd1;
            end
        end else if (load_pend) begin
            pend_vld <= 1'b0;
        end
    end

    // Inter-frame gap counter, cleared whenever the sequencer is outside GAP.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            gap_cnt <= '0;
        end else if ((state_q == ST_GAP) && !gap_last) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    // Chip select registered from the next state so the pin is glitch-free and falls one cycle after valid.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            csn_q <= 1'b1;
        end else begin
            csn_q <= !(state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
        end
    end

`ifdef DAC_LDAC_EN
    logic ldacn_q;

    // LDAC strobe registered from the next state, low for the whole LDAC state.
    always_ff @(posedge clk_sys or posedge sys_rst) begin
        if (sys_rst) begin
            ldacn_q <= 1'b1;
        end else begin
            ldacn_q <= (state_nxt != ST_LDAC);
        end
    end

    assign dac_ldacn = ldacn_q;
`else
    // Without the strobe the DAC latches on the csn rising edge.
    assign dac_ldacn = 1'b1;
`endif

    assign dac_busy    = (state_q != ST_IDLE);
    assign dac_done    = (state_q == ST_GAP) && gap_last;
    assign dac_overrun = overrun_q;
    assign dac_sclk    = sclk_q;
    assign dac_mosi    = shift_q[FRAME_BITS-1];
    assign dac_csn     = csn_q;

endmodule

// File: tb/tb_pos_dac_spi_tx.sv
// Purpose: self-checking bench for pos_dac_spi_tx against a frame-timing reference model.
// Latency: model predicts every pin per cycle from frame start and word; SPI words captured on SCLK rises.
// Backpressure: stimulus ignores busy, exercising the pending slot and overrun counter.
module tb_pos_dac_spi_tx;
    import galvano_dac_pkg::*;

    localparam int         D   = 4;
    localparam int         G   = 2;
    localparam logic [7:0] CMD = 8'h00;
`ifdef DAC_LDAC_EN
    localparam int LD = D;
`else
    localparam int LD = 0;
`endif
    localparam int F = 50 * D + LD + G;

    logic        clk_sys = 1'b0;
    logic        sys_rst;
    logic        dac_code_valid;
    logic [15:0] dac_code;
    logic        dac_busy;
    logic        dac_done;
    logic [15:0] dac_overrun;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_csn;
    logic        dac_ldacn;

    always #5 clk_sys = ~clk_sys;

    pos_dac_spi_tx #(
        .CLK_DIV  (D),
        .CMD_BYTE (CMD),
        .CS_GAP   (G)
    ) dut (
        .clk_sys        (clk_sys),
        .sys_rst        (sys_rst),
        .dac_code_valid (dac_code_valid),
        .dac_code       (dac_code),
        .dac_busy       (dac_busy),
        .dac_done       (dac_done),
        .dac_overrun    (dac_overrun),
        .dac_sclk       (dac_sclk),
        .dac_mosi       (dac_mosi),
        .dac_csn        (dac_csn),
        .dac_ldacn      (dac_ldacn)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is "busy" from its start cycle s to its done cycle s+F.
    int          cyc_n = 0;
    logic        m_busy;
    int          m_start;
    logic [23:0] m_word;
    logic        m_pend_vld;
    logic [15:0] m_pend;
    logic [15:0] m_ovr;
    logic [23:0] exp_q[$];

    // SPI monitor state
    logic [23:0] cap;
    int          nbits;
    logic        prev_sclk;
    logic        prev_csn;
    int          last_done;
    int          ldac_low_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_start    = 0;
        m_word     = '0;
        m_pend_vld = 1'b0;
        m_pend     = '0;
        m_ovr      = '0;
        exp_q.delete();
        cap        = '0;
        nbits      = 0;
        prev_sclk  = 1'b0;
        prev_csn   = 1'b1;
    endtask

    task automatic model_start(input logic [15:0] code);
        m_busy  = 1'b1;
        m_start = cyc_n;
        m_word  = {CMD, code};
        exp_q.push_back(m_word);
    endtask

    task automatic model_step(input logic v, input logic [15:0] code);
        logic idle_c;
        logic took;
        idle_c = !m_busy;
        took   = 1'b0;
        if (m_busy && (cyc_n - m_start) == F) begin
            if (m_pend_vld) begin
                model_start(m_pend);
                m_pend_vld = 1'b0;
                took = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else if (!m_busy && m_pend_vld) begin
            model_start(m_pend);
            m_pend_vld = 1'b0;
            took = 1'b1;
        end
        if (v) begin
            if (idle_c && !took) begin
                model_start(code);
            end else begin
                if (m_pend_vld && m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
                m_pend     = code;
                m_pend_vld = 1'b1;
            end
        end
    endtask

    // Expected pin values for the current cycle, from the offset k into the frame.
    task automatic check_cycle();
        int   k;
        int   idx;
        logic e_sclk;
        k      = cyc_n - m_start;
        e_sclk = m_busy && k >= D + 1 && k <= 49 * D && (((k - D - 1) % (2 * D)) >= D);
        chk("busy",    dac_busy,    m_busy);
        chk("csn",     dac_csn,     !(m_busy && k >= 1 && k <= 50 * D));
        chk("sclk",    dac_sclk,    e_sclk);
        chk("ldacn",   dac_ldacn,   !(LD != 0 && m_busy && k >= 50 * D + 1 && k <= 50 * D + LD));
        chk("done",    dac_done,    m_busy && k == F);
        chk("overrun", dac_overrun, m_ovr);
        if (m_busy && k >= 1 && k <= 49 * D) begin
            idx = (k <= D) ? 23 : 23 - ((k - D - 1) / (2 * D));
            chk("mosi", dac_mosi, m_word[idx]);
        end
        if (dac_done) last_done = cyc_n;
        if (!dac_ldacn) ldac_low_cnt++;
    endtask

    // Capture the word as the DAC would see it: one bit per SCLK rise, word closes on csn rise.
    task automatic monitor();
        if (dac_sclk && !prev_sclk) begin
            cap = {cap[22:0], dac_mosi};
            nbits++;
        end
        if (dac_csn && !prev_csn) begin
            chk("frame_bits", nbits, 24);
            if (exp_q.size() == 0) chk("frame_expected", exp_q.size(), 1);
            else                   chk("frame_word", cap, exp_q.pop_front());
            cap   = '0;
            nbits = 0;
        end
        prev_sclk = dac_sclk;
        prev_csn  = dac_csn;
    endtask

    task automatic cyc(input logic v, input logic [15:0] code);
        @(negedge clk_sys);
        check_cycle();
        monitor();
        dac_code_valid = v;
        dac_code       = code;
        model_step(v, code);
        cyc_n++;
    endtask

    int t0;
    int l0;

    initial begin
        sys_rst        = 1'b1;
        dac_code_valid = 1'b0;
        dac_code       = '0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        chk("rst_csn",     dac_csn,     1);
        chk("rst_sclk",    dac_sclk,    0);
        chk("rst_mosi",    dac_mosi,    0);
        chk("rst_ldacn",   dac_ldacn,   1);
        chk("rst_busy",    dac_busy,    0);
        chk("rst_done",    dac_done,    0);
        chk("rst_overrun", dac_overrun, 0);
        sys_rst = 1'b0;

        // Quiet interface after reset release
        repeat (500) cyc(1'b0, 16'h0);

        // Single mid-scale code: latency to done and LDAC pulse length
        t0 = cyc_n;
        l0 = ldac_low_cnt;
        cyc(1'b1, DAC_MIDSCALE);
        repeat (F + 10) cyc(1'b0, 16'h0);
        chk("single_done_latency", last_done - t0, F);
        chk("single_ldac_cycles",  ldac_low_cnt - l0, LD);
        chk("single_words_left",   exp_q.size(), 0);

        // Two codes 10 cycles apart: back-to-back frames
        cyc(1'b1, 16'h1234);
        repeat (9) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'hABCD);
        repeat (2 * F + 10) cyc(1'b0, 16'h0);
        chk("b2b_overrun",    dac_overrun, 0);
        chk("b2b_words_left", exp_q.size(), 0);

        // A starts a frame, B then C land during it: B is overwritten
        cyc(1'b1, 16'hAAAA);
        repeat (29) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'hBBBB);
        repeat (29) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'hCCCC);
        repeat (2 * F + 10) cyc(1'b0, 16'h0);
        chk("abc_overrun",    dac_overrun, 1);
        chk("abc_words_left", exp_q.size(), 0);

        // Code on the done cycle, another on the following idle cycle
        cyc(1'b1, 16'h5A5A);
        for (int i = 0; i < F + 5 && !(m_busy && (cyc_n - m_start) == F); i++) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h0F0F);
        cyc(1'b1, 16'hF0F0);
        repeat (3 * F + 10) cyc(1'b0, 16'h0);
        chk("edge_overrun",    dac_overrun, 1);
        chk("edge_words_left", exp_q.size(), 0);

        // Reset in the middle of bit 12 while SCLK is high
        cyc(1'b1, 16'hC3A5);
        for (int i = 0; i < 300 && !(m_busy && (cyc_n - m_start) == 98); i++) cyc(1'b0, 16'h0);
        #2;
        sys_rst        = 1'b1;
        dac_code_valid = 1'b0;
        #1;
        chk("midrst_csn",     dac_csn,     1);
        chk("midrst_sclk",    dac_sclk,    0);
        chk("midrst_busy",    dac_busy,    0);
        chk("midrst_overrun", dac_overrun, 0);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        sys_rst = 1'b0;
        model_reset();
        cyc(1'b1, 16'h0001);
        repeat (F + 10) cyc(1'b0, 16'h0);
        chk("post_rst_words_left", exp_q.size(), 0);

        // Sparse random codes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) cyc(1'b1, 16'($urandom));
            else                           cyc(1'b0, 16'h0);
        end
        // Dense random codes to exercise overwrites
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 15) cyc(1'b1, 16'($urandom));
            else                            cyc(1'b0, 16'h0);
        end
        repeat (2 * F + 20) cyc(1'b0, 16'h0);
        chk("drain_words_left", exp_q.size(), 0);
        chk("drain_busy",       dac_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
